// File: rtl/knn_topk_core.sv
// knn_topk_core: serial squared-Euclidean distance of streamed training points against a
// loaded test point, keeping a distance-sorted list of the K nearest labelled neighbours.
module knn_topk_core #(
   parameter int COORD_W = 8,
   parameter int N_DIM   = 2,
   parameter int K       = 4,
   parameter int LABEL_W = 8,
   parameter int DIST_W  = 32,
   localparam int CNT_W  = $clog2(K + 1),
   localparam int IDX_W  = (K > 1) ? $clog2(K) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     test_load,
   input  logic [N_DIM*COORD_W-1:0] test_point,
   input  logic                     train_valid,
   output logic                     train_ready,
   input  logic [N_DIM*COORD_W-1:0] train_point,
   input  logic [LABEL_W-1:0]       train_label,
   output logic                     ins_done,
   output logic [CNT_W-1:0]         ins_pos,
   output logic [CNT_W-1:0]         count,
   input  logic [IDX_W-1:0]         rd_idx,
   output logic [DIST_W-1:0]        rd_dist,
   output logic [LABEL_W-1:0]       rd_label
);
   localparam int SQ_W  = 2 * COORD_W + 2;
   localparam int DIM_W = (N_DIM > 1) ? $clog2(N_DIM) : 1;
   localparam logic [DIM_W-1:0]   DIM_LAST    = DIM_W'(N_DIM - 1);
   localparam logic [DIM_W-1:0]   DIM_ONE     = DIM_W'(1);
   localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0]   CNT_K       = CNT_W'(K);
   localparam logic [DIST_W-1:0]  DIST_EMPTY  = {DIST_W{1'b1}};
   localparam logic [LABEL_W-1:0] LABEL_EMPTY = {LABEL_W{1'b0}};

   if (DIST_W < SQ_W + $clog2(N_DIM)) begin : g_dist_w_check
      $error("knn_topk_core: DIST_W too narrow to hold the summed squared differences");
   end

   typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, INSERT = 2'd2} state_t;

   state_t                     state_r;
   logic [N_DIM*COORD_W-1:0]   test_r;
   logic [N_DIM*COORD_W-1:0]   train_r;
   logic [LABEL_W-1:0]         label_r;
   logic [DIST_W-1:0]          acc_r;
   logic [DIM_W-1:0]           dim_r;
   logic [DIST_W-1:0]          dist_r [K];
   logic [LABEL_W-1:0]         lbl_r  [K];
   logic [CNT_W-1:0]           count_r;
   logic [CNT_W-1:0]           ins_pos_r;
   logic                       ins_done_r;

   logic signed [COORD_W-1:0]  test_c_s  [N_DIM];
   logic signed [COORD_W-1:0]  train_c_s [N_DIM];
   logic signed [COORD_W:0]    diff_s;
   logic signed [SQ_W-1:0]     prod_s;
   logic [SQ_W-1:0]            sq_s;
   logic [CNT_W-1:0]           pos_s;
   logic [DIST_W-1:0]          nd_s [K];
   logic [LABEL_W-1:0]         nl_s [K];

   for (genvar g = 0; g < N_DIM; g++) begin : g_coord
      assign test_c_s[g]  = test_r[g*COORD_W +: COORD_W];
      assign train_c_s[g] = train_r[g*COORD_W +: COORD_W];
   end

   // Squared difference of the current dimension; the square of a signed value is never negative.
   always_comb begin
      diff_s = (COORD_W+1)'(test_c_s[dim_r]) - (COORD_W+1)'(train_c_s[dim_r]);
      prod_s = SQ_W'(diff_s) * SQ_W'(diff_s);
      sq_s   = $unsigned(prod_s);
   end

   // Insertion slot = occupied entries with dist <= acc; ties land after equal entries.
   always_comb begin
      pos_s = {CNT_W{1'b0}};
      for (int i = 0; i < K; i++) begin
         if ((CNT_W'(i) < count_r) && (dist_r[i] <= acc_r)) begin
            pos_s = pos_s + CNT_ONE;
         end else begin
            pos_s = pos_s;
         end
      end
   end

   // Candidate list with the new point placed at pos_s and the tail shifted down by one.
   always_comb begin
      if (pos_s == {CNT_W{1'b0}}) begin
         nd_s[0] = acc_r;
         nl_s[0] = label_r;
      end else begin
         nd_s[0] = dist_r[0];
         nl_s[0] = lbl_r[0];
      end
      for (int i = 1; i < K; i++) begin
         if (CNT_W'(i) < pos_s) begin
            nd_s[i] = dist_r[i];
            nl_s[i] = lbl_r[i];
         end else if (CNT_W'(i) == pos_s) begin
            nd_s[i] = acc_r;
            nl_s[i] = label_r;
         end else begin
            nd_s[i] = dist_r[i-1];
            nl_s[i] = lbl_r[i-1];
         end
      end
   end

   // Control FSM, accumulator and sorted neighbour list.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         test_r     <= {(N_DIM*COORD_W){1'b0}};
         train_r    <= {(N_DIM*COORD_W){1'b0}};
         label_r    <= LABEL_EMPTY;
         acc_r      <= {DIST_W{1'b0}};
         dim_r      <= {DIM_W{1'b0}};
         count_r    <= {CNT_W{1'b0}};
         ins_pos_r  <= {CNT_W{1'b0}};
         ins_done_r <= 1'b0;
         for (int i = 0; i < K; i++) begin
            dist_r[i] <= DIST_EMPTY;
            lbl_r[i]  <= LABEL_EMPTY;
         end
      end else if (test_load) begin
         state_r    <= IDLE;
         test_r     <= test_point;
         count_r    <= {CNT_W{1'b0}};
         ins_done_r <= 1'b0;
         for (int i = 0; i < K; i++) begin
            dist_r[i] <= DIST_EMPTY;
            lbl_r[i]  <= LABEL_EMPTY;
         end
      end else begin
         ins_done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (train_valid) begin
                  train_r <= train_point;
                  label_r <= train_label;
                  acc_r   <= {DIST_W{1'b0}};
                  dim_r   <= {DIM_W{1'b0}};
                  state_r <= ACC;
               end
            end
            ACC: begin
               acc_r <= acc_r + DIST_W'(sq_s);
               if (dim_r == DIM_LAST) begin
                  state_r <= INSERT;
               end else begin
                  dim_r <= dim_r + DIM_ONE;
               end
            end
            INSERT: begin
               if (pos_s < CNT_K) begin
                  for (int i = 0; i < K; i++) begin
                     dist_r[i] <= nd_s[i];
                     lbl_r[i]  <= nl_s[i];
                  end
                  if (count_r != CNT_K) begin
                     count_r <= count_r + CNT_ONE;
                  end
               end
               ins_pos_r  <= pos_s;
               ins_done_r <= 1'b1;
               state_r    <= IDLE;
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   assign train_ready = (state_r == IDLE) && !rst;
   assign ins_done    = ins_done_r;
   assign ins_pos     = ins_pos_r;
   assign count       = count_r;
   assign rd_dist     = (CNT_W'(rd_idx) < count_r) ? dist_r[rd_idx] : DIST_EMPTY;
   assign rd_label    = (CNT_W'(rd_idx) < count_r) ? lbl_r[rd_idx]  : LABEL_EMPTY;

endmodule

// File: tb/tb_knn_topk_core.sv
// Self-checking bench for knn_topk_core: directed vector table, abort sequences and
// randomized points compared against a sorted-queue reference model.
module tb_knn_topk_core;
   localparam int COORD_W = 8;
   localparam int N_DIM   = 2;
   localparam int K       = 4;
   localparam int LABEL_W = 8;
   localparam int DIST_W  = 32;

   logic        clk = 1'b0;
   logic        rst, test_load, train_valid, train_ready, ins_done;
   logic [15:0] test_point, train_point;
   logic [7:0]  train_label, rd_label;
   logic [2:0]  ins_pos, count;
   logic [1:0]  rd_idx;
   logic [31:0] rd_dist;

   int errors = 0;
   int checks = 0;
   int tx = 0, ty = 0;
   int last_pos = 0;
   longint mq_d[$];
   int     mq_l[$];

   typedef struct {
      bit     load;
      int     tx, ty, px, py, lb;
      int     exp_pos, exp_cnt;
      longint exp_dist;
   } vec_t;
   vec_t tbl[10];

   knn_topk_core #(.COORD_W(COORD_W), .N_DIM(N_DIM), .K(K), .LABEL_W(LABEL_W), .DIST_W(DIST_W)) dut (
      .clk(clk), .rst(rst), .test_load(test_load), .test_point(test_point),
      .train_valid(train_valid), .train_ready(train_ready), .train_point(train_point),
      .train_label(train_label), .ins_done(ins_done), .ins_pos(ins_pos), .count(count),
      .rd_idx(rd_idx), .rd_dist(rd_dist), .rd_label(rd_label)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic logic [15:0] pack(input int x, input int y);
      logic [7:0] xb, yb;
      xb = x[7:0];
      yb = y[7:0];
      return {yb, xb};
   endfunction

   // Reference: sorted list, new entry goes after all entries with dist <= d, truncated to K.
   function automatic int model_insert(input longint d, input int l);
      int p = 0;
      foreach (mq_d[i]) if (mq_d[i] <= d) p++;
      if (p < K) begin
         mq_d.insert(p, d);
         mq_l.insert(p, l);
         if (mq_d.size() > K) begin
            void'(mq_d.pop_back());
            void'(mq_l.pop_back());
         end
      end
      return p;
   endfunction

   task automatic check_list(input string tag);
      for (int i = 0; i < K; i++) begin
         rd_idx = 2'(i);
         #1;
         chk($sformatf("%s_dist%0d", tag, i), rd_dist, (i < mq_d.size()) ? mq_d[i] : 64'hFFFFFFFF);
         chk($sformatf("%s_label%0d", tag, i), rd_label, (i < mq_l.size()) ? mq_l[i] : 0);
      end
   endtask

   task automatic push(input int px, input int py, input int lb, input string tag);
      longint d;
      int p, lat;
      d = (tx - px) * (tx - px) + (ty - py) * (ty - py);
      chk({tag, "_ready"}, train_ready, 1);
      train_point = pack(px, py);
      train_label = 8'(lb);
      train_valid = 1'b1;
      @(posedge clk); #1;
      train_valid = 1'b0;
      lat = 1;
      while (!ins_done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_latency"}, lat, 4);
      p = model_insert(d, lb);
      chk({tag, "_pos"}, ins_pos, p);
      chk({tag, "_count"}, count, mq_d.size());
      last_pos = p;
      check_list(tag);
   endtask

   task automatic wait_quiet(input string tag);
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (ins_done) seen++;
      end
      chk({tag, "_no_done"}, seen, 0);
   endtask

   task automatic load(input int x, input int y, input logic with_valid, input string tag);
      tx = x;
      ty = y;
      test_point  = pack(x, y);
      train_point = pack(1, 1);
      test_load   = 1'b1;
      train_valid = with_valid;
      @(posedge clk); #1;
      test_load   = 1'b0;
      train_valid = 1'b0;
      mq_d.delete();
      mq_l.delete();
      chk({tag, "_ready"}, train_ready, 1);
      chk({tag, "_count"}, count, 0);
      chk({tag, "_inspos_hold"}, ins_pos, last_pos);
      chk({tag, "_done"}, ins_done, 0);
   endtask

   initial begin
      tbl[0] = '{1'b0,    0,    0,   3,   4,  7, 0, 1, 25};
      tbl[1] = '{1'b1,    0,    0,   3,   4,  1, 0, 1, 25};
      tbl[2] = '{1'b0,    0,    0,   1,   0,  2, 0, 2, 1};
      tbl[3] = '{1'b0,    0,    0,   0,   3,  3, 1, 3, 9};
      tbl[4] = '{1'b0,    0,    0,   0,   4,  4, 2, 4, 16};
      tbl[5] = '{1'b0,    0,    0,   5,   1,  8, 4, 4, 26};
      tbl[6] = '{1'b0,    0,    0,   2,   0,  9, 1, 4, 4};
      tbl[7] = '{1'b0,    0,    0,   3,   0, 10, 3, 4, 9};
      tbl[8] = '{1'b0,    0,    0,  -3,   0, 11, 4, 4, 9};
      tbl[9] = '{1'b1, -128, -128, 127, 127,  5, 0, 1, 130050};

      rst = 1'b1; test_load = 1'b0; train_valid = 1'b0; rd_idx = 2'd0;
      test_point = 16'h0000; train_point = 16'h0000; train_label = 8'h00;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         chk("rst_done", ins_done, 0);
         chk("rst_ready_low", train_ready, 0);
      end
      rst = 1'b0;
      #1;
      chk("rst_ready", train_ready, 1);
      chk("rst_count", count, 0);
      chk("rst_inspos", ins_pos, 0);
      check_list("rst");

      // Directed table: single point from reset state, fill/sort, full list, ties, extremes.
      for (int v = 0; v < 10; v++) begin
         if (tbl[v].load) load(tbl[v].tx, tbl[v].ty, 1'b0, $sformatf("v%0d_load", v));
         push(tbl[v].px, tbl[v].py, tbl[v].lb, $sformatf("v%0d", v));
         chk($sformatf("v%0d_tpos", v), ins_pos, tbl[v].exp_pos);
         chk($sformatf("v%0d_tcnt", v), count, tbl[v].exp_cnt);
         if (tbl[v].exp_pos < K) begin
            rd_idx = 2'(tbl[v].exp_pos);
            #1;
            chk($sformatf("v%0d_tdist", v), rd_dist, tbl[v].exp_dist);
            chk($sformatf("v%0d_tlabel", v), rd_label, tbl[v].lb);
         end
         if (v == 8) begin
            rd_idx = 2'd2; #1;
            chk("tie_first_label", rd_label, 3);
            rd_idx = 2'd3; #1;
            chk("tie_second_label", rd_label, 10);
         end
         @(posedge clk); #1;
         chk($sformatf("v%0d_pulse", v), ins_done, 0);
      end

      // Abort an in-flight point with test_load during ACC.
      load(0, 0, 1'b0, "ab_load");
      push(3, 4, 7, "ab_pre");
      train_point = pack(1, 1);
      train_valid = 1'b1;
      @(posedge clk); #1;
      train_valid = 1'b0;
      test_point  = pack(0, 0);
      test_load   = 1'b1;
      @(posedge clk); #1;
      test_load = 1'b0;
      mq_d.delete();
      mq_l.delete();
      chk("abort_ready", train_ready, 1);
      chk("abort_count", count, 0);
      wait_quiet("abort");
      chk("abort_inspos_hold", ins_pos, last_pos);
      check_list("abort");

      // test_load and train_valid together in IDLE: point must be refused.
      load(0, 0, 1'b1, "lv");
      wait_quiet("lv");
      chk("lv_count_after", count, 0);

      // Randomized rounds: wide coordinates, then clustered ones to force ties.
      for (int r = 0; r < 3; r++) begin
         if (r == 1) load(0, 0, 1'b0, "r1_load");
         else if (r == 2) load(-128, 127, 1'b0, "r2_load");
         else load(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, 1'b0, "r0_load");
         for (int n = 0; n < 15; n++) begin
            int px, py;
            if (r == 1) begin
               px = int'($urandom_range(0, 4)) - 2;
               py = int'($urandom_range(0, 4)) - 2;
            end else begin
               px = int'($urandom_range(0, 255)) - 128;
               py = int'($urandom_range(0, 255)) - 128;
            end
            push(px, py, int'($urandom_range(0, 255)), $sformatf("r%0d_%0d", r, n));
         end
      end

      // Reset in the middle of operation clears everything.
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst2_ready_low", train_ready, 0);
      rst = 1'b0;
      #1;
      mq_d.delete();
      mq_l.delete();
      last_pos = 0;
      chk("rst2_count", count, 0);
      chk("rst2_inspos", ins_pos, 0);
      chk("rst2_ready", train_ready, 1);
      check_list("rst2");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
